cnn_stream_arbiter: RTL and testbench
=====================================

Name: cnn_stream_arbiter

Overview:
- Shares one 32-bit datapath (the 2:1 stream mux feeding the conv-layer input bus) between two requesting streams, e.g. the feature-map reader and the weight loader.
- Arbitrates round-robin at packet granularity and drives the mux select.
- Registers the selected beat into an output stage with a valid/ready handshake toward the downstream PE array.

Parameters:
- DATA_W, 32, width of in0_data, in1_data and out_data.
- MAX_BURST, 16, maximum beats per grant before forced release. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DATA_W  requester 0 beat.
- in0_last  input  1  final beat of requester 0 packet.
- in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  DATA_W  requester 1 beat.
- in1_last  input  1  final beat of requester 1 packet.
- in1_ready  output  1  requester 1 beat accepted when high with in1_valid.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  DATA_W  registered selected beat.
- out_last  output  1  registered last flag; also 1 for the final beat of a MAX_BURST cut.
- out_ready  input  1  downstream accepts the beat.
- mux_sel  output  1  datapath select: 0 = in0, 1 = in1.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, takes effect immediately): state = IDLE, out_valid = 0, out_data = 0, out_last = 0, mux_sel = 0, busy = 0, beat count = 0, priority pointer = in0.
- Reset mid-burst: the output register contents are discarded, not delivered.
- FSM states: IDLE, GRANT0, GRANT1. mux_sel = 1 only in GRANT1; busy = (state != IDLE). Both are registered, derived from state.
- IDLE transitions:
  - only in0_valid -> GRANT0.
  - only in1_valid -> GRANT1.
  - both valid -> grant the pointer side.
  - no beat is accepted in the IDLE cycle (one arbitration bubble).
- Accept rule in GRANTx: inx_ready = (!out_valid || out_ready). The non-granted ready is always 0. In IDLE, both readies are 0.
- Transfer: on inx_valid && inx_ready, the output register loads data. out_valid becomes 1 on the next edge, so latency is 1 cycle. The beat count increments.
- Output stage:
  - out_valid clears when out_ready is high and no new beat is loaded.
  - out_data and out_last hold stable while out_valid && !out_ready.
- End of grant: on the accepting cycle where inx_last = 1 or count+1 == MAX_BURST:
  - out_last is loaded as 1;
  - next state = IDLE, count = 0;
  - the pointer moves to the other requester.
  - The requester must resume a cut packet in a later grant; the arbiter adds no packet state.
- Lost grant: if inx_valid deasserts while granted, the grant is held. No timeout is applied.
- Simultaneous events: the end-of-grant beat plus the downstream pop in the same cycle gives full throughput, with no extra bubble beyond IDLE.
- Fairness: when both requesters are continuously valid, grants alternate 0,1,0,1.
- Requester inputs are sampled only when accepted. The protocol requires the requester to hold valid, data and last stable until ready.

Test Plan:
- Single packet: after reset, in0 sends 3 beats 0x11,0x22,0x33 (last on 0x33) with out_ready = 1.
  -> out_data 0x11,0x22,0x33 on 3 consecutive cycles starting 2 cycles after in0_valid rises; out_last = 1 only on 0x33; mux_sel stays 0; FSM ends in IDLE.
- Contention: both requesters hold a 2-beat packet (in0: 0xA0,0xA1; in1: 0xB0,0xB1) from reset.
  -> output order A0,A1,B0,B1; mux_sel 0 then 1; one IDLE bubble between packets.
- Round-robin: both continuously send 1-beat packets (last = 1).
  -> grants alternate 0,1,0,1 over 8 packets; no requester granted twice consecutively.
- Backpressure: in1 sends 4 beats; out_ready low for 3 cycles after the first beat.
  -> out_data stable at beat 0 and in1_ready = 0 while stalled; all 4 beats are then delivered in order with none lost or duplicated.
- MAX_BURST = 4: in0 sends a 6-beat packet while in1 waits.
  -> beats 0-3 delivered with out_last = 1 on beat 3; then in1's packet; then in0 beats 4-5.
- Reset mid-burst: assert reset during beat 2 of a 5-beat in0 packet.
  -> out_valid = 0, mux_sel = 0 and busy = 0 immediately, without waiting for a clock; after release, a new in1 packet is granted and delivered normally.

Source files
------------

// File: rtl/cnn_stream_arbiter.sv
// Round-robin, packet-granular arbiter sharing one datapath between two streams,
// with a registered valid/ready output stage toward the PE array.
module cnn_stream_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              mux_sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t            state;
  logic              ptr;
  logic [7:0]        count;
  logic              can_load;
  logic              accept;
  logic              sel_last;
  logic              end_grant;
  logic [DATA_W-1:0] sel_data;

  // The output register may take a new beat when empty or being drained this cycle.
  assign can_load  = !out_valid || out_ready;
  assign in0_ready = (state == GRANT0) && can_load;
  assign in1_ready = (state == GRANT1) && can_load;
  assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

  assign sel_data  = mux_sel ? in1_data : in0_data;
  assign sel_last  = mux_sel ? in1_last : in0_last;

  // A grant ends on the packet's last beat or when the burst budget is used up.
  assign end_grant = sel_last || (({1'b0, count} + 9'd1) == 9'(MAX_BURST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      count     <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      mux_sel   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= end_grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in0_valid && (!in1_valid || !ptr)) begin
            state   <= GRANT0;
            busy    <= 1'b1;
            mux_sel <= 1'b0;
          end else if (in1_valid) begin
            state   <= GRANT1;
            busy    <= 1'b1;
            mux_sel <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            if (end_grant) begin
              state   <= IDLE;
              count   <= 8'd0;
              ptr     <= (state == GRANT0);
              busy    <= 1'b0;
              mux_sel <= 1'b0;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mux_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_stream_arbiter.sv
// Directed and randomized checks of cnn_stream_arbiter against a packet-level
// reference model of round-robin arbitration with MAX_BURST cuts.
module tb_cnn_stream_arbiter;

  localparam int DW = 32;
  localparam int MB = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in0_valid, in0_last, in0_ready;
  logic          in1_valid, in1_last, in1_ready;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          out_valid, out_last, out_ready, mux_sel, busy;

  int compared   = 0;
  int mismatched = 0;

  beat_t q0[$], q1[$], exp_q[$];
  int    len0[$], len1[$], grant_q[$];

  cnn_stream_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .mux_sel(mux_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] d0, input logic l0,
                               input logic v1, input logic [31:0] d1, input logic l1,
                               input logic ordy);
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet-level model: pointer side wins if it has work, grants take at most MB beats.
  task automatic buildExpected();
    int rem0[$], rem1[$];
    int idx0, idx1, ptr, g, n;
    beat_t b;
    rem0 = len0; rem1 = len1;
    idx0 = 0; idx1 = 0; ptr = 0;
    while (rem0.size() > 0 || rem1.size() > 0) begin
      if (ptr == 0) g = (rem0.size() > 0) ? 0 : 1;
      else          g = (rem1.size() > 0) ? 1 : 0;
      n = (g == 0) ? rem0[0] : rem1[0];
      if (n > MB) n = MB;
      for (int k = 0; k < n; k++) begin
        b = (g == 0) ? q0[idx0] : q1[idx1];
        b.last = (k == n - 1);
        exp_q.push_back(b);
        if (g == 0) idx0++; else idx1++;
      end
      if (g == 0) begin
        rem0[0] -= n;
        if (rem0[0] == 0) void'(rem0.pop_front());
      end else begin
        rem1[0] -= n;
        if (rem1[0] == 0) void'(rem1.pop_front());
      end
      grant_q.push_back(g);
      ptr = 1 - g;
    end
  endtask

  task automatic presentHeads();
    in0_valid = (q0.size() > 0);
    in0_data  = (q0.size() > 0) ? q0[0].data : 32'h0;
    in0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    in1_valid = (q1.size() > 0);
    in1_data  = (q1.size() > 0) ? q1[0].data : 32'h0;
    in1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  initial begin
    logic        acc0, acc1, stalled, held_last, prev_busy;
    logic [31:0] held_data;
    int          cyc, plen, g;
    beat_t       b;

    // Reset values, visible before any clock edge.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_readies", {30'd0, in1_ready, in0_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single 3-beat packet from in0.
    $display("[TB] single packet");
    applyStimulus(1, 32'h11, 0, 0, 0, 0, 1);
    tick();
    checkOutput("sp_busy", 32'(busy), 32'd1);
    checkOutput("sp_bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("sp_in0_ready", 32'(in0_ready), 32'd1);
    tick();
    checkOutput("sp_b0_data", out_data, 32'h11);
    checkOutput("sp_b0_last", 32'(out_last), 32'd0);
    applyStimulus(1, 32'h22, 0, 0, 0, 0, 1);
    tick();
    checkOutput("sp_b1_data", out_data, 32'h22);
    applyStimulus(1, 32'h33, 1, 0, 0, 0, 1);
    tick();
    checkOutput("sp_b2_data", out_data, 32'h33);
    checkOutput("sp_b2_last", 32'(out_last), 32'd1);
    checkOutput("sp_mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("sp_idle", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("sp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a 5-beat in0 packet.
    $display("[TB] reset mid-burst");
    applyStimulus(1, 32'h50, 0, 0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(1, 32'h51, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 32'h52, 0, 0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mr_mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'hC0, 0, 1);
    tick();
    checkOutput("mr_grant1_sel", 32'(mux_sel), 32'd1);
    tick();
    checkOutput("mr_c0", out_data, 32'hC0);
    applyStimulus(0, 0, 0, 1, 32'hC1, 1, 1);
    tick();
    checkOutput("mr_c1", out_data, 32'hC1);
    checkOutput("mr_c1_last", 32'(out_last), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Randomized contention with backpressure against the packet-level model.
    $display("[TB] randomized contention");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 8; p++) begin
        plen = (p < 2) ? 1 : int'($urandom_range(1, 7));
        for (int k = 0; k < plen; k++) begin
          b.data = $urandom;
          b.last = (k == plen - 1);
          if (r == 0) q0.push_back(b); else q1.push_back(b);
        end
        if (r == 0) len0.push_back(plen); else len1.push_back(plen);
      end
    end
    buildExpected();
    presentHeads();
    out_ready = 1'b1;
    stalled = 1'b0; prev_busy = 1'b0; held_data = 32'h0; held_last = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (stalled) begin
        checkOutput("hold_data", out_data, held_data);
        checkOutput("hold_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        checkOutput("rnd_data", out_data, b.data);
        checkOutput("rnd_last", 32'(out_last), 32'(b.last));
      end
      if (out_valid && !out_ready)
        checkOutput("stall_ready", {30'd0, in1_ready, in0_ready}, 32'd0);
      if (busy && !prev_busy) begin
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 2;
        checkOutput("grant_side", 32'(mux_sel), 32'(g));
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      prev_busy = busy;
      tick();
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      presentHeads();
      out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    compared++;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL timeout remaining=%0d required=0", exp_q.size());
    end
    checkOutput("grants_left", 32'(grant_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
